cmp_serial: RTL and testbench

//  Multi-cycle, parametrised successor to the 8-bit equality comparator.

---
 rtl/cmp_serial_if.sv | 28 ++
 rtl/cmp_serial.sv | 128 ++++++++++++
 tb/tb_cmp_serial.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_serial_if.sv
// cmp_serial_if: request/result bundle for the serial comparator.
//   start  request strobe (master -> slave)
//   mode   00=EQ 01=NE 10=LT signed 11=LT unsigned (master -> slave)
//   x, y   N-bit operands (master -> slave)
//   busy   compare in progress (slave -> master)
//   done   one-cycle result-valid pulse (slave -> master)
//   r      result, held until the next accepted start (slave -> master)
interface cmp_serial_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic [1:0]   mode;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic         r;

  modport master (
    output start, mode, x, y,
    input  busy, done, r
  );

  modport slave (
    input  start, mode, x, y,
    output busy, done, r
  );
endinterface

// File: rtl/cmp_serial.sv
// cmp_serial: multi-cycle comparator, N-bit operands examined D bits per
// cycle, most significant digit first. Supports EQ, NE, signed LT and
// unsigned LT. Fixed latency of N/D+1 edges from acceptance to done.
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   bus_io  slave side of cmp_serial_if (start/mode/x/y in, busy/done/r out)
module cmp_serial #(
  parameter int unsigned N = 8,
  parameter int unsigned D = 1
) (
  input logic         clk,
  input logic         rst,
  cmp_serial_if.slave bus_io
);

  localparam int unsigned Digits = N / D;
  localparam int unsigned KW     = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [KW-1:0] KMax = KW'(Digits - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic [1:0]    mode_q, mode_d;
  logic [KW-1:0] k_q, k_d;
  logic          dif_q, dif_d;
  logic          lt_q, lt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          r_q, r_d;

  logic [N-1:0]  x_sh, y_sh;
  logic [D-1:0]  x_dig, y_dig;

  always_comb begin
    x_sh  = x_q >> (D * 32'(k_q));
    y_sh  = y_q >> (D * 32'(k_q));
    x_dig = x_sh[D-1:0];
    y_dig = y_sh[D-1:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    k_d     = k_q;
    dif_d   = dif_q;
    lt_d    = lt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;

    // busy covers the done cycle and drops on the following edge
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start && !busy_q) begin
          x_d    = bus_io.x;
          y_d    = bus_io.y;
          // Flipping both sign bits maps signed order onto unsigned order
          if (bus_io.mode == 2'b10) begin
            x_d[N-1] = ~bus_io.x[N-1];
            y_d[N-1] = ~bus_io.y[N-1];
          end
          mode_d  = bus_io.mode;
          dif_d   = 1'b0;
          lt_d    = 1'b0;
          k_d     = KMax;
          busy_d  = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // First differing digit from the top decides the ordering
        if (!dif_q && (x_dig != y_dig)) begin
          dif_d = 1'b1;
          lt_d  = (x_dig < y_dig);
        end
        if (k_q == '0) state_d = StDone;
        else           k_d     = k_q - 1'b1;
      end
      StDone: begin
        done_d = 1'b1;
        unique case (mode_q)
          2'b00:   r_d = ~dif_q;
          2'b01:   r_d = dif_q;
          default: r_d = dif_q & lt_q;
        endcase
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      k_q     <= '0;
      dif_q   <= 1'b0;
      lt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      dif_q   <= dif_d;
      lt_q    <= lt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.r    = r_q;

endmodule

// File: tb/tb_cmp_serial.sv
module tb_cmp_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_serial_if #(.N(8))  if8 ();
  cmp_serial_if #(.N(16)) if16 ();

  cmp_serial #(.N(8), .D(1)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if8)
  );

  cmp_serial #(.N(16), .D(4)) u_dut16 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (if16)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  logic sb_q[$];
  logic last_r8  = 1'b0;
  logic last_r16 = 1'b0;

  localparam logic [1:0] MEq = 2'b00, MNe = 2'b01, MLts = 2'b10, MLtu = 2'b11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result computed straight from the operand values
  function automatic logic model(input int w, input logic [1:0] m,
                                 input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] sa, sb;
    logic [15:0] ua, ub;
    if (w == 8) begin
      ua = {8'h00, a[7:0]};
      ub = {8'h00, b[7:0]};
      sa = {{9{a[7]}}, a[7:0]};
      sb = {{9{b[7]}}, b[7:0]};
    end else begin
      ua = a;
      ub = b;
      sa = {a[15], a};
      sb = {b[15], b};
    end
    case (m)
      MEq:     return ua == ub;
      MNe:     return ua != ub;
      MLts:    return sa < sb;
      default: return ua < ub;
    endcase
  endfunction

  task automatic drive(input bit sel, input logic st, input logic [1:0] m,
                       input logic [15:0] a, input logic [15:0] b);
    if (sel) begin
      if16.start = st; if16.mode = m; if16.x = a; if16.y = b;
    end else begin
      if8.start = st; if8.mode = m; if8.x = a[7:0]; if8.y = b[7:0];
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? if16.busy : if8.busy;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? if16.done : if8.done;
  endfunction
  function automatic logic get_r(input bit sel);
    return sel ? if16.r : if8.r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic cmp(input bit sel, input logic [1:0] m, input logic [15:0] a,
                     input logic [15:0] b, input string tag, input bit intrude);
    int   lat;
    bit   seen;
    logic exp;
    logic prev_r;
    prev_r = sel ? last_r16 : last_r8;
    drive(sel, 1'b1, m, a, b);
    sb_q.push_back(model(sel ? 16 : 8, m, a, b));
    @(negedge clk);
    // Scramble operands after acceptance; must not affect the result
    drive(sel, 1'b0, ~m, ~a, b ^ 16'h5a5a);
    check({tag, "_busy_on"}, 32'(get_busy(sel)), 32'd1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (intrude && lat == 2) drive(sel, 1'b1, MNe, 16'd3, 16'd3);
      else                     drive(sel, 1'b0, MEq, 16'd0, 16'd0);
      if (lat == 1) check({tag, "_r_held"}, 32'(get_r(sel)), 32'(prev_r));
      if (get_done(sel)) seen = 1;
    end
    check({tag, "_latency"}, 32'(lat), sel ? 32'd5 : 32'd9);
    exp = sb_q.pop_front();
    if (seen) begin
      check({tag, "_r"}, 32'(get_r(sel)), 32'(exp));
      check({tag, "_busy_in_done"}, 32'(get_busy(sel)), 32'd1);
    end
    if (sel) last_r16 = exp; else last_r8 = exp;
    drive(sel, 1'b0, MEq, 16'd0, 16'd0);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(get_done(sel)), 32'd0);
    check({tag, "_busy_fall"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic no_done(input bit sel, input int cycles, input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (get_done(sel)) cnt++;
    end
    check({tag, "_no_extra_done"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, MEq, 16'd0, 16'd0);
    drive(1, 1'b0, MEq, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(if8.busy), 32'd0);
    check("rst_done8", 32'(if8.done), 32'd0);
    check("rst_r8", 32'(if8.r), 32'd0);
    check("rst_busy16", 32'(if16.busy), 32'd0);
    check("rst_done16", 32'(if16.done), 32'd0);
    check("rst_r16", 32'(if16.r), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    cmp(0, MEq,  16'h05, 16'h05, "t1_eq_5_5", 0);
    cmp(0, MLts, 16'hF9, 16'h05, "t2_lts_m7_5", 0);
    cmp(0, MLtu, 16'hF9, 16'h05, "t2_ltu_249_5", 0);
    cmp(0, MLts, 16'h80, 16'h7F, "t2_lts_m128_127", 0);
    cmp(0, MNe,  16'h80, 16'h7F, "t3_ne_m128_127", 0);
    cmp(0, MNe,  16'hFF, 16'hFF, "t3_ne_m1_m1", 0);
    cmp(0, MLts, 16'h03, 16'h03, "t3_lts_3_3", 0);
    cmp(0, MEq,  16'h80, 16'h00, "eq_80_00", 0);
    cmp(0, MLtu, 16'h00, 16'hFF, "ltu_0_255", 0);
    cmp(0, MLts, 16'h05, 16'hF9, "lts_5_m7", 0);

    cmp(0, MEq, 16'h01, 16'h02, "t4_ignored_start", 1);
    no_done(0, 12, "t4");

    cmp(0, MEq, 16'h09, 16'h09, "t5_pre", 0);
    drive(0, 1'b1, MEq, 16'h09, 16'h09);
    @(negedge clk);
    drive(0, 1'b0, MEq, 16'h00, 16'h00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_r8 = 1'b0;
    check("t5_abort_busy", 32'(if8.busy), 32'd0);
    check("t5_abort_done", 32'(if8.done), 32'd0);
    check("t5_abort_r", 32'(if8.r), 32'd0);
    no_done(0, 15, "t5");

    cmp(1, MLtu, 16'h1234, 16'h1235, "t6_ltu_1234_1235", 0);
    cmp(1, MEq,  16'hFFFF, 16'hFFFF, "t6_eq_ffff", 0);
    cmp(1, MLts, 16'h8000, 16'h0001, "lts16_min_1", 0);
    cmp(1, MLts, 16'h0001, 16'hFFFF, "lts16_1_m1", 0);
    cmp(1, MNe,  16'hA5A5, 16'hA5A4, "ne16_lsb", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
